itch_msg_arbiter: RTL and testbench
===================================

# itch_msg_arbiter

Merges the outputs of the four speculative ITCH decoders (add, cancel, delete, replace) into one ordered result stream. The block sits beside the decoders on the same `byte_in`/`valid_in` bus. It frames messages from the type byte and expected length. For each completed message it accepts exactly one result from the decoder whose type matches. It buffers accepted results in a small FIFO behind a valid/ready handshake toward the order-book stage, and counts every class of rejected or lost message.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: result FIFO entries; power of two, ≥2.
- `RESULT_TIMEOUT`, 4: cycles after the last byte within which the matching decoder must respond; range 1–15.

Ports:
- `clk` in 1: single clock. One clock; reset is synchronous and active-high.
- `rst` in 1: synchronous, active-high reset.
- `byte_in` in 8, `valid_in` in 1: shared ITCH byte stream, identical to the decoders' inputs.
- `add_internal_valid`, `add_packet_invalid` in 1 each, plus `add_order_ref` 64, `add_side` 1, `add_shares` 32, `add_price` 32, `add_stock_symbol` 64: add decoder result.
- `cancel_internal_valid`, `cancel_packet_invalid` in 1 each, plus `cancel_order_ref` 64, `cancel_canceled_shares` 32: cancel decoder result.
- `delete_internal_valid`, `delete_packet_invalid` in 1 each, plus `delete_order_ref` 64: delete decoder result.
- `replace_internal_valid`, `replace_packet_invalid` in 1 each, plus `replace_old_order_ref` 64, `replace_new_order_ref` 64, `replace_shares` 32, `replace_price` 32: replace decoder result.
- `out_valid` out 1, `out_ready` in 1: result handshake.
- `out_type` out 2: 0=add, 1=cancel, 2=delete, 3=replace.
- `out_order_ref` out 64: order ref, or old ref for replace.
- `out_new_order_ref` out 64: new ref; replace only, else 0.
- `out_side` out 1.
- `out_shares` out 32: shares, or canceled shares for cancel.
- `out_price` out 32.
- `out_stock_symbol` out 64.
- Fields not carried by a type are 0.
- `err_unknown`, `err_trunc`, `err_invalid`, `err_conflict`, `err_timeout`, `drop_overflow` out 16 each: saturating event counters.

## Operation
Framer FSM:
- States: IDLE, IN_MSG, DISCARD.
- IDLE, valid byte:
  - Type byte `'A'`(0x41): length 36. `'X'`(0x58): length 23. `'D'`(0x44): length 19. `'U'`(0x55): length 35.
  - Known type: latch type, `cnt=1`, go to IN_MSG.
  - Any other type: `err_unknown++`, go to DISCARD.
- IN_MSG:
  - Each valid byte: `cnt++`.
  - Valid byte with `cnt==len-1`: message complete, go to IDLE, arm the collector.
  - `valid_in` low for any cycle: `err_trunc++`, go to IDLE, do not arm the collector.
- DISCARD: stay until the first cycle with `valid_in` low, then go to IDLE.

Collector (pending flag, type, timer):
- Armed on the completion edge: `pending=1`, `timer=0`.
- Evaluated each cycle while pending, in this priority order:
  - Any non-matching decoder's `internal_valid` high: `err_conflict++`, clear pending.
  - Matching decoder's `packet_invalid` high: `err_invalid++`, clear pending.
  - Matching decoder's `internal_valid` high: capture its fields into the unified result, push to the FIFO, clear pending.
  - `timer==RESULT_TIMEOUT-1`: `err_timeout++`, clear pending.
  - Otherwise: `timer++`.
- Decoder outputs are ignored while not pending.
- Because 19 > 15, at most one message is ever pending. A new message may be framed while the previous one is still pending.

FIFO:
- `out_valid` = not empty. The head drives the `out_*` fields.
- Pop on `out_valid && out_ready`.
- Push when full: allowed if a pop occurs in the same cycle; otherwise the result is dropped and `drop_overflow++`.

Counters: saturate at 0xFFFF.

## Timing
- Reset: FSM in IDLE, pending=0, FIFO empty, `out_valid=0`, all `out_*` fields 0, all counters 0.
- `rst` asserted mid-message or mid-pending discards all state. Bytes arriving after release are framed from IDLE, so they start a new message.
- Latency: the matching decoder's `internal_valid` in cycle N produces `out_valid` in cycle N+1 when the FIFO was empty and not blocked.
- `out_*` fields are stable while `out_valid && !out_ready`.
- Back-to-back messages with no gap are supported: the type byte of message k+1 arrives the cycle after the last byte of message k.

## Structure
- `itch_pkg` holds:
  - Type byte constants and length constants (36/23/19/35).
  - `msg_type_e` enum, encoding 0–3.
  - The `itch_result_t` packed struct: type plus unified fields.
- Sub-module `result_fifo`: synchronous FIFO parameterised by depth and element type, with full, empty, push and pop.
- Counters use one shared saturating-increment function, defined in the package.

## Test plan
- Single delete (0x44, 18 payload bytes); `delete_internal_valid` 1 cycle after the last byte with ref 0x1122334455667788 → `out_valid`, `out_type=2`, `out_order_ref=0x1122334455667788`, all other fields 0.
- Add (36 bytes) immediately followed by replace (35 bytes), `out_ready=1` → two results in order, types 0 then 3, all fields match the decoder values.
- Type byte 0x5A followed by 10 bytes, a one-cycle gap, then a valid cancel → `err_unknown=1`, the cancel is emitted with `out_type=1`.
- Cancel with `valid_in` dropped at byte 10 → `err_trunc=1`, no output even if `cancel_internal_valid` later pulses. Separately, a completed add with no decoder response for 4 cycles → `err_timeout=1`.
- Completed add, both `add_internal_valid` and `cancel_internal_valid` high in the same cycle → `err_conflict=1`, no output. Separately, `add_packet_invalid` high → `err_invalid=1`.
- `out_ready=0`, 5 deletes sent with `FIFO_DEPTH=4` → 4 held, `drop_overflow=1`. Then `out_ready=1` → the 4 held results drain in order, one per cycle.

Source files
------------

// File: rtl/itch_pkg.sv
// Shared ITCH type/length constants, unified result payload and counter helpers.
package itch_pkg;

  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned REF_W   = 64;
  localparam int unsigned QTY_W   = 32;
  localparam int unsigned PRICE_W = 32;
  localparam int unsigned SYM_W   = 64;
  localparam int unsigned CNT_W   = 6;
  localparam int unsigned CTR_W   = 16;
  localparam int unsigned TIMER_W = 4;

  localparam logic [BYTE_W-1:0] TYPE_BYTE_ADD     = 8'h41;
  localparam logic [BYTE_W-1:0] TYPE_BYTE_CANCEL  = 8'h58;
  localparam logic [BYTE_W-1:0] TYPE_BYTE_DELETE  = 8'h44;
  localparam logic [BYTE_W-1:0] TYPE_BYTE_REPLACE = 8'h55;

  localparam logic [CNT_W-1:0] LEN_ADD     = 6'd36;
  localparam logic [CNT_W-1:0] LEN_CANCEL  = 6'd23;
  localparam logic [CNT_W-1:0] LEN_DELETE  = 6'd19;
  localparam logic [CNT_W-1:0] LEN_REPLACE = 6'd35;

  typedef enum logic [1:0] {
    MSG_ADD     = 2'd0,
    MSG_CANCEL  = 2'd1,
    MSG_DELETE  = 2'd2,
    MSG_REPLACE = 2'd3
  } msg_type_e;

  typedef struct packed {
    msg_type_e            msg_type;
    logic [REF_W-1:0]     order_ref;
    logic [REF_W-1:0]     new_order_ref;
    logic                 side;
    logic [QTY_W-1:0]     shares;
    logic [PRICE_W-1:0]   price;
    logic [SYM_W-1:0]     stock_symbol;
  } itch_result_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] v);
    return (v == {CTR_W{1'b1}}) ? v : v + CTR_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] msg_len(input msg_type_e t);
    logic [CNT_W-1:0] len;
    case (t)
      MSG_ADD:     len = LEN_ADD;
      MSG_CANCEL:  len = LEN_CANCEL;
      MSG_DELETE:  len = LEN_DELETE;
      default:     len = LEN_REPLACE;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/itch_msg_arbiter_if.sv
// Result stream toward the order-book stage: valid/ready plus unified fields.
interface itch_msg_arbiter_if;
  import itch_pkg::*;

  logic                 out_valid;
  logic                 out_ready;
  logic [1:0]           out_type;
  logic [REF_W-1:0]     out_order_ref;
  logic [REF_W-1:0]     out_new_order_ref;
  logic                 out_side;
  logic [QTY_W-1:0]     out_shares;
  logic [PRICE_W-1:0]   out_price;
  logic [SYM_W-1:0]     out_stock_symbol;

  modport master (
    output out_valid, out_type, out_order_ref, out_new_order_ref,
           out_side, out_shares, out_price, out_stock_symbol,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_type, out_order_ref, out_new_order_ref,
           out_side, out_shares, out_price, out_stock_symbol,
    output out_ready
  );
endinterface

// File: rtl/result_fifo.sv
// Synchronous FIFO of generic elements; head is zero while empty.
module result_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter type         T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  T     wr_data,
  input  logic pop,
  output T     rd_data,
  output logic full,
  output logic empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T           mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/itch_msg_arbiter.sv
// Frames ITCH messages, accepts one matching decoder result per message and
// queues it toward the order book, counting every rejected or lost message.
module itch_msg_arbiter
  import itch_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned RESULT_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   byte_in,
  input  logic                valid_in,

  input  logic                add_internal_valid,
  input  logic                add_packet_invalid,
  input  logic [REF_W-1:0]    add_order_ref,
  input  logic                add_side,
  input  logic [QTY_W-1:0]    add_shares,
  input  logic [PRICE_W-1:0]  add_price,
  input  logic [SYM_W-1:0]    add_stock_symbol,

  input  logic                cancel_internal_valid,
  input  logic                cancel_packet_invalid,
  input  logic [REF_W-1:0]    cancel_order_ref,
  input  logic [QTY_W-1:0]    cancel_canceled_shares,

  input  logic                delete_internal_valid,
  input  logic                delete_packet_invalid,
  input  logic [REF_W-1:0]    delete_order_ref,

  input  logic                replace_internal_valid,
  input  logic                replace_packet_invalid,
  input  logic [REF_W-1:0]    replace_old_order_ref,
  input  logic [REF_W-1:0]    replace_new_order_ref,
  input  logic [QTY_W-1:0]    replace_shares,
  input  logic [PRICE_W-1:0]  replace_price,

  itch_msg_arbiter_if.master  res_if,

  output logic [CTR_W-1:0]    err_unknown,
  output logic [CTR_W-1:0]    err_trunc,
  output logic [CTR_W-1:0]    err_invalid,
  output logic [CTR_W-1:0]    err_conflict,
  output logic [CTR_W-1:0]    err_timeout,
  output logic [CTR_W-1:0]    drop_overflow
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_IN_MSG  = 2'd1,
    S_DISCARD = 2'd2
  } frame_state_e;

  frame_state_e       state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  msg_type_e          cur_type, cur_type_nxt;
  logic               complete_c, unknown_c, trunc_c;
  logic               type_known_c;
  msg_type_e          byte_type_c;

  // Type byte decode.
  always_comb begin
    type_known_c = 1'b1;
    byte_type_c  = MSG_ADD;
    case (byte_in)
      TYPE_BYTE_ADD:     byte_type_c = MSG_ADD;
      TYPE_BYTE_CANCEL:  byte_type_c = MSG_CANCEL;
      TYPE_BYTE_DELETE:  byte_type_c = MSG_DELETE;
      TYPE_BYTE_REPLACE: byte_type_c = MSG_REPLACE;
      default:           type_known_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      cur_type <= MSG_ADD;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      cur_type <= cur_type_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    cur_type_nxt = cur_type;
    complete_c   = 1'b0;
    unknown_c    = 1'b0;
    trunc_c      = 1'b0;
    case (state)
      S_IDLE: begin
        if (valid_in) begin
          if (type_known_c) begin
            cur_type_nxt = byte_type_c;
            cnt_nxt      = CNT_W'(1);
            state_nxt    = S_IN_MSG;
          end else begin
            unknown_c = 1'b1;
            state_nxt = S_DISCARD;
          end
        end
      end
      S_IN_MSG: begin
        if (!valid_in) begin
          trunc_c   = 1'b1;
          state_nxt = S_IDLE;
        end else if (cnt == msg_len(cur_type) - CNT_W'(1)) begin
          complete_c = 1'b1;
          state_nxt  = S_IDLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_DISCARD: begin
        if (!valid_in) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Collector: one outstanding message awaiting its decoder verdict.
  logic                pending;
  msg_type_e           pend_type;
  logic [TIMER_W-1:0]  timer;
  logic [3:0]          dec_valid, dec_invalid, match_mask;
  logic [1:0]          pend_idx;
  logic                other_valid_c, conflict_c, invalid_c, accept_c, timeout_c;

  assign dec_valid   = {replace_internal_valid, delete_internal_valid,
                        cancel_internal_valid,  add_internal_valid};
  assign dec_invalid = {replace_packet_invalid, delete_packet_invalid,
                        cancel_packet_invalid,  add_packet_invalid};
  assign pend_idx    = pend_type;
  assign match_mask  = 4'b0001 << pend_idx;

  assign other_valid_c = |(dec_valid & ~match_mask);
  assign conflict_c    = pending && other_valid_c;
  assign invalid_c     = pending && !other_valid_c && dec_invalid[pend_idx];
  assign accept_c      = pending && !other_valid_c && !dec_invalid[pend_idx] && dec_valid[pend_idx];
  assign timeout_c     = pending && !other_valid_c && !dec_invalid[pend_idx] && !dec_valid[pend_idx]
                         && (timer == TIMER_W'(RESULT_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      pending   <= 1'b0;
      pend_type <= MSG_ADD;
      timer     <= '0;
    end else if (complete_c) begin
      pending   <= 1'b1;
      pend_type <= cur_type;
      timer     <= '0;
    end else if (conflict_c || invalid_c || accept_c || timeout_c) begin
      pending   <= 1'b0;
    end else if (pending) begin
      timer     <= timer + TIMER_W'(1);
    end
  end

  // Map the matching decoder's fields onto the unified result.
  itch_result_t res_c;
  always_comb begin
    res_c          = '0;
    res_c.msg_type = pend_type;
    case (pend_type)
      MSG_ADD: begin
        res_c.order_ref    = add_order_ref;
        res_c.side         = add_side;
        res_c.shares       = add_shares;
        res_c.price        = add_price;
        res_c.stock_symbol = add_stock_symbol;
      end
      MSG_CANCEL: begin
        res_c.order_ref = cancel_order_ref;
        res_c.shares    = cancel_canceled_shares;
      end
      MSG_DELETE: begin
        res_c.order_ref = delete_order_ref;
      end
      default: begin
        res_c.order_ref     = replace_old_order_ref;
        res_c.new_order_ref = replace_new_order_ref;
        res_c.shares        = replace_shares;
        res_c.price         = replace_price;
      end
    endcase
  end

  itch_result_t head;
  logic         fifo_full, fifo_empty, pop_c, drop_c;

  assign pop_c  = !fifo_empty && res_if.out_ready;
  assign drop_c = accept_c && fifo_full && !pop_c;

  result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (itch_result_t)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept_c),
    .wr_data (res_c),
    .pop     (pop_c),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign res_if.out_valid         = !fifo_empty;
  assign res_if.out_type          = head.msg_type;
  assign res_if.out_order_ref     = head.order_ref;
  assign res_if.out_new_order_ref = head.new_order_ref;
  assign res_if.out_side          = head.side;
  assign res_if.out_shares        = head.shares;
  assign res_if.out_price         = head.price;
  assign res_if.out_stock_symbol  = head.stock_symbol;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_unknown   <= '0;
      err_trunc     <= '0;
      err_invalid   <= '0;
      err_conflict  <= '0;
      err_timeout   <= '0;
      drop_overflow <= '0;
    end else begin
      if (unknown_c)  err_unknown   <= sat_inc(err_unknown);
      if (trunc_c)    err_trunc     <= sat_inc(err_trunc);
      if (invalid_c)  err_invalid   <= sat_inc(err_invalid);
      if (conflict_c) err_conflict  <= sat_inc(err_conflict);
      if (timeout_c)  err_timeout   <= sat_inc(err_timeout);
      if (drop_c)     drop_overflow <= sat_inc(drop_overflow);
    end
  end

endmodule

// File: tb/tb_itch_msg_arbiter.sv
// Directed bench for itch_msg_arbiter: framing, verdict priority, timeout and FIFO backpressure.
module tb_itch_msg_arbiter;
  import itch_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] byte_in = '0;
  logic valid_in = 1'b0;

  logic add_iv = 0, add_pi = 0, add_side = 0;
  logic [63:0] add_ref = '0, add_sym = '0;
  logic [31:0] add_shares = '0, add_price = '0;
  logic cancel_iv = 0, cancel_pi = 0;
  logic [63:0] cancel_ref = '0;
  logic [31:0] cancel_shares = '0;
  logic delete_iv = 0, delete_pi = 0;
  logic [63:0] delete_ref = '0;
  logic replace_iv = 0, replace_pi = 0;
  logic [63:0] replace_old = '0, replace_new = '0;
  logic [31:0] replace_shares = '0, replace_price = '0;

  logic [15:0] err_unknown, err_trunc, err_invalid, err_conflict, err_timeout, drop_overflow;

  int total = 0;
  int bad   = 0;

  itch_msg_arbiter_if ifc();

  itch_msg_arbiter #(.FIFO_DEPTH(4), .RESULT_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .valid_in(valid_in),
    .add_internal_valid(add_iv), .add_packet_invalid(add_pi), .add_order_ref(add_ref),
    .add_side(add_side), .add_shares(add_shares), .add_price(add_price), .add_stock_symbol(add_sym),
    .cancel_internal_valid(cancel_iv), .cancel_packet_invalid(cancel_pi),
    .cancel_order_ref(cancel_ref), .cancel_canceled_shares(cancel_shares),
    .delete_internal_valid(delete_iv), .delete_packet_invalid(delete_pi), .delete_order_ref(delete_ref),
    .replace_internal_valid(replace_iv), .replace_packet_invalid(replace_pi),
    .replace_old_order_ref(replace_old), .replace_new_order_ref(replace_new),
    .replace_shares(replace_shares), .replace_price(replace_price),
    .res_if(ifc),
    .err_unknown(err_unknown), .err_trunc(err_trunc), .err_invalid(err_invalid),
    .err_conflict(err_conflict), .err_timeout(err_timeout), .drop_overflow(drop_overflow)
  );

  always #5 clk = ~clk;

  // Handshake monitor, sampled on the falling edge.
  logic mon_en = 1'b0;
  itch_result_t got_q[$];
  always @(negedge clk) begin
    if (mon_en && ifc.out_valid && ifc.out_ready) begin
      itch_result_t r;
      r.msg_type      = msg_type_e'(ifc.out_type);
      r.order_ref     = ifc.out_order_ref;
      r.new_order_ref = ifc.out_new_order_ref;
      r.side          = ifc.out_side;
      r.shares        = ifc.out_shares;
      r.price         = ifc.out_price;
      r.stock_symbol  = ifc.out_stock_symbol;
      got_q.push_back(r);
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid_in = 1'b0; ifc.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic send_msg(input logic [7:0] t, input int len);
    for (int i = 0; i < len; i++) begin
      valid_in = 1'b1;
      byte_in  = (i == 0) ? t : 8'(i);
      tick();
    end
    valid_in = 1'b0;
    byte_in  = '0;
  endtask

  task automatic test_reset();
    ifc.out_ready = 1'b0;
    do_reset();
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0h want 0", ifc.out_valid); end
    total++; if (ifc.out_order_ref !== 64'h0 || ifc.out_type !== 2'd0 || ifc.out_shares !== 32'h0)
      begin bad++; $display("FAIL reset_fields: ref %0h type %0h shares %0h want 0", ifc.out_order_ref, ifc.out_type, ifc.out_shares); end
    total++; if ({err_unknown, err_trunc, err_invalid, err_conflict, err_timeout, drop_overflow} !== 96'h0)
      begin bad++; $display("FAIL reset_counters: got %0h want 0", {err_unknown, err_trunc, err_invalid, err_conflict, err_timeout, drop_overflow}); end
  endtask

  task automatic test_single_delete();
    do_reset();
    send_msg(8'h44, 19);
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL del_early: got %0h want 0", ifc.out_valid); end
    delete_ref = 64'h1122334455667788; delete_iv = 1'b1;
    tick();
    delete_iv = 1'b0;
    total++; if (ifc.out_valid !== 1'b1) begin bad++; $display("FAIL del_latency: got %0h want 1", ifc.out_valid); end
    total++; if (ifc.out_type !== 2'd2) begin bad++; $display("FAIL del_type: got %0h want 2", ifc.out_type); end
    total++; if (ifc.out_order_ref !== 64'h1122334455667788) begin bad++; $display("FAIL del_ref: got %0h want 1122334455667788", ifc.out_order_ref); end
    total++; if (ifc.out_new_order_ref !== 64'h0 || ifc.out_side !== 1'b0 || ifc.out_shares !== 32'h0 ||
                 ifc.out_price !== 32'h0 || ifc.out_stock_symbol !== 64'h0)
      begin bad++; $display("FAIL del_zero_fields: new %0h side %0h sh %0h pr %0h sym %0h want 0", ifc.out_new_order_ref, ifc.out_side, ifc.out_shares, ifc.out_price, ifc.out_stock_symbol); end
    tick();
    total++; if (ifc.out_valid !== 1'b1 || ifc.out_order_ref !== 64'h1122334455667788)
      begin bad++; $display("FAIL del_hold: valid %0h ref %0h want 1 1122334455667788", ifc.out_valid, ifc.out_order_ref); end
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL del_pop: got %0h want 0", ifc.out_valid); end
  endtask

  task automatic test_back_to_back();
    itch_result_t e0, e1;
    do_reset();
    add_ref = 64'hA1A2A3A4A5A6A7A8; add_side = 1'b1; add_shares = 32'd100;
    add_price = 32'd12345; add_sym = 64'h4141504C20202020;
    replace_old = 64'h0102030405060708; replace_new = 64'h1112131415161718;
    replace_shares = 32'd200; replace_price = 32'd999;
    e0 = '{msg_type: MSG_ADD, order_ref: 64'hA1A2A3A4A5A6A7A8, new_order_ref: 64'h0, side: 1'b1,
           shares: 32'd100, price: 32'd12345, stock_symbol: 64'h4141504C20202020};
    e1 = '{msg_type: MSG_REPLACE, order_ref: 64'h0102030405060708, new_order_ref: 64'h1112131415161718,
           side: 1'b0, shares: 32'd200, price: 32'd999, stock_symbol: 64'h0};
    got_q.delete();
    ifc.out_ready = 1'b1; mon_en = 1'b1;
    for (int i = 0; i < 71; i++) begin
      valid_in = 1'b1;
      byte_in  = (i == 0) ? 8'h41 : (i == 36) ? 8'h55 : 8'(i);
      add_iv   = (i == 36);
      tick();
    end
    valid_in = 1'b0; add_iv = 1'b0; replace_iv = 1'b1;
    tick();
    replace_iv = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mon_en = 1'b0; ifc.out_ready = 1'b0;
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0] !== e0) begin bad++; $display("FAIL b2b_add: got %h want %h", got_q[0], e0); end
      total++; if (got_q[1] !== e1) begin bad++; $display("FAIL b2b_replace: got %h want %h", got_q[1], e1); end
    end
  endtask

  task automatic test_unknown();
    do_reset();
    send_msg(8'h5A, 11);
    tick();
    send_msg(8'h58, 23);
    cancel_ref = 64'hCAFE; cancel_shares = 32'd77; cancel_iv = 1'b1;
    tick();
    cancel_iv = 1'b0;
    total++; if (err_unknown !== 16'd1) begin bad++; $display("FAIL unk_count: got %0d want 1", err_unknown); end
    total++; if (ifc.out_valid !== 1'b1 || ifc.out_type !== 2'd1)
      begin bad++; $display("FAIL unk_cancel_out: valid %0h type %0h want 1 1", ifc.out_valid, ifc.out_type); end
    total++; if (ifc.out_order_ref !== 64'hCAFE || ifc.out_shares !== 32'd77)
      begin bad++; $display("FAIL unk_cancel_fields: ref %0h sh %0d want cafe 77", ifc.out_order_ref, ifc.out_shares); end
  endtask

  task automatic test_trunc_timeout();
    do_reset();
    send_msg(8'h58, 10);
    tick();
    cancel_iv = 1'b1;
    tick();
    cancel_iv = 1'b0;
    tick();
    total++; if (err_trunc !== 16'd1) begin bad++; $display("FAIL trunc_count: got %0d want 1", err_trunc); end
    total++; if (ifc.out_valid !== 1'b0 || err_conflict !== 16'd0)
      begin bad++; $display("FAIL trunc_no_out: valid %0h conflict %0d want 0 0", ifc.out_valid, err_conflict); end
    do_reset();
    send_msg(8'h41, 36);
    for (int i = 0; i < 3; i++) tick();
    total++; if (err_timeout !== 16'd0) begin bad++; $display("FAIL timeout_early: got %0d want 0", err_timeout); end
    tick();
    total++; if (err_timeout !== 16'd1) begin bad++; $display("FAIL timeout_count: got %0d want 1", err_timeout); end
    add_iv = 1'b1;
    tick();
    add_iv = 1'b0;
    tick();
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL timeout_late_resp: got %0h want 0", ifc.out_valid); end
  endtask

  task automatic test_conflict_invalid();
    do_reset();
    send_msg(8'h41, 36);
    add_iv = 1'b1; cancel_iv = 1'b1;
    tick();
    add_iv = 1'b0; cancel_iv = 1'b0;
    tick();
    total++; if (err_conflict !== 16'd1 || ifc.out_valid !== 1'b0)
      begin bad++; $display("FAIL conflict: count %0d valid %0h want 1 0", err_conflict, ifc.out_valid); end
    do_reset();
    send_msg(8'h41, 36);
    add_pi = 1'b1; add_iv = 1'b1;
    tick();
    add_pi = 1'b0; add_iv = 1'b0;
    tick();
    total++; if (err_invalid !== 16'd1 || ifc.out_valid !== 1'b0)
      begin bad++; $display("FAIL invalid: count %0d valid %0h want 1 0", err_invalid, ifc.out_valid); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      send_msg(8'h44, 19);
      delete_ref = 64'(k); delete_iv = 1'b1;
      tick();
      delete_iv = 1'b0;
    end
    total++; if (drop_overflow !== 16'd1) begin bad++; $display("FAIL ovf_count: got %0d want 1", drop_overflow); end
    ifc.out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (ifc.out_valid !== 1'b1 || ifc.out_order_ref !== 64'(k))
        begin bad++; $display("FAIL ovf_drain_%0d: valid %0h ref %0h want 1 %0h", k, ifc.out_valid, ifc.out_order_ref, k); end
      tick();
    end
    total++; if (ifc.out_valid !== 1'b0) begin bad++; $display("FAIL ovf_empty: got %0h want 0", ifc.out_valid); end
    ifc.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_msg();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      valid_in = 1'b1; byte_in = (i == 0) ? 8'h41 : 8'(i); tick();
    end
    rst = 1'b1; byte_in = 8'h55;
    tick(); tick();
    rst = 1'b0;
    send_msg(8'h44, 19);
    delete_ref = 64'hD00D; delete_iv = 1'b1;
    tick();
    delete_iv = 1'b0;
    total++; if (ifc.out_valid !== 1'b1 || ifc.out_type !== 2'd2 || ifc.out_order_ref !== 64'hD00D)
      begin bad++; $display("FAIL rst_mid_out: valid %0h type %0h ref %0h want 1 2 d00d", ifc.out_valid, ifc.out_type, ifc.out_order_ref); end
    total++; if (err_trunc !== 16'd0 || err_unknown !== 16'd0)
      begin bad++; $display("FAIL rst_mid_counters: trunc %0d unk %0d want 0 0", err_trunc, err_unknown); end
  endtask

  initial begin
    ifc.out_ready = 1'b0;
    test_reset();
    test_single_delete();
    test_back_to_back();
    test_unknown();
    test_trunc_timeout();
    test_conflict_invalid();
    test_overflow();
    test_reset_mid_msg();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
